// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Reset/lock sequencer for the rPLL clock generator. Runs on the
//               PLL reference clock, pulses the PLL RESET pin, watches LOCK,
//               and holds system reset until lock has been stable for a set
//               time. Retries the PLL on lock timeout, re-sequences it on lock
//               loss in service, and keeps a saturating retry count plus a
//               sticky lock-lost flag for debug/LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 270000,
    parameter int STABLE_CYCLES  = 2700,
    parameter int RETRY_WIDTH    = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock,
    input  logic                   clear_flags,
    output logic                   pll_reset,
    output logic                   sys_rst,
    output logic                   ready,
    output logic [1:0]             state,
    output logic [RETRY_WIDTH-1:0] retry_count,
    output logic                   lock_lost
);

    // ------------------------------------------------------------------------
    // Counter sizing: wide enough for the longest phase. Every phase ends on
    // its terminal count (N-1), so the counter never needs to hold N itself.
    // ------------------------------------------------------------------------
    localparam int c_MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_MAX    = (c_MAX_AB > STABLE_CYCLES) ? c_MAX_AB : STABLE_CYCLES;
    localparam int c_CNT_W  = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    localparam logic [RETRY_WIDTH-1:0] c_RETRY_ONE = RETRY_WIDTH'(1);

    // State encoding is visible on the state port, so it is fixed here.
    localparam logic [1:0] c_ST_RESET_PLL = 2'b00;
    localparam logic [1:0] c_ST_WAIT_LOCK = 2'b01;
    localparam logic [1:0] c_ST_STABLE    = 2'b10;
    localparam logic [1:0] c_ST_RUN       = 2'b11;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;

    logic                   w_retry_inc;
    logic                   w_lost_set;

    logic                   r_pll_reset;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic [RETRY_WIDTH-1:0] r_retry;
    logic                   r_lost;

    // ------------------------------------------------------------------------
    // LOCK is asynchronous to clk; only the last stage is ever looked at.
    // ------------------------------------------------------------------------
    // Shift pll_lock through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    // State and shared phase counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RESET_PLL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and flag-event decode. Any transition reloads the
    // counter to zero so each phase is timed from its own entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_retry_inc = 1'b0;
        w_lost_set  = 1'b0;
        case (r_state)
            c_ST_RESET_PLL: begin
                // LOCK is meaningless while the PLL is held in reset.
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (w_lock_s) begin
                    w_state_nxt = c_ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_state_nxt = c_ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                    w_retry_inc = 1'b1;
                end
            end
            c_ST_STABLE: begin
                // A glitch in lock sends us back to waiting, without a retry.
                if (!w_lock_s) begin
                    w_state_nxt = c_ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_STB_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_RUN: begin
                // Counter parks at zero in service so it can never overflow.
                w_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = c_ST_RESET_PLL;
                    w_retry_inc = 1'b1;
                    w_lost_set  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs are registered from the next state so they change on the same
    // edge as the state register and can never disagree with it.
    // ------------------------------------------------------------------------
    // Registered control outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pll_reset <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_pll_reset <= (w_state_nxt == c_ST_RESET_PLL);
            r_sys_rst   <= (w_state_nxt != c_ST_RUN);
            r_ready     <= (w_state_nxt == c_ST_RUN);
        end
    end

    // ------------------------------------------------------------------------
    // Debug flags. A coincident event beats clear_flags so an event landing on
    // the clear cycle is never lost.
    // ------------------------------------------------------------------------
    // Saturating retry counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry <= '0;
        end else if (w_retry_inc) begin
            if (clear_flags) begin
                r_retry <= c_RETRY_ONE;
            end else if (!(&r_retry)) begin
                r_retry <= r_retry + c_RETRY_ONE;
            end
        end else if (clear_flags) begin
            r_retry <= '0;
        end
    end

    // Sticky lock-lost flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lost <= 1'b0;
        end else if (w_lost_set) begin
            r_lost <= 1'b1;
        end else if (clear_flags) begin
            r_lost <= 1'b0;
        end
    end

    assign pll_reset   = r_pll_reset;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign state       = r_state;
    assign retry_count = r_retry;
    assign lock_lost   = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_sequencer
// Description : Scoreboard bench for pll_lock_sequencer. Stimulus schedules
//               expected output snapshots keyed by clock edge; a monitor on
//               the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       pll_lock    = 1'b0;
    logic       clear_flags = 1'b0;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [3:0] retry_count;
    logic       lock_lost;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .RETRY_WIDTH    (4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .clear_flags (clear_flags),
        .pll_reset   (pll_reset),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .state       (state),
        .retry_count (retry_count),
        .lock_lost   (lock_lost)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        string      nm;
        logic [1:0] st;
        logic [3:0] rc;
        logic       ll;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic expect_at(input int c, input string nm, input logic [1:0] st,
                             input logic [3:0] rc, input logic ll);
        exp_t e;
        e.c  = c;
        e.nm = nm;
        e.st = st;
        e.rc = rc;
        e.ll = ll;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic logic [3:0] sat15(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    function automatic void check(input exp_t e);
        logic xpr, xsr, xrdy;
        xpr  = (e.st == 2'd0);
        xsr  = (e.st != 2'd3);
        xrdy = (e.st == 2'd3);
        n_vec++;
        if ({state, pll_reset, sys_rst, ready, retry_count, lock_lost} !==
            {e.st, xpr, xsr, xrdy, e.rc, e.ll}) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got st=%0d pr=%b sr=%b rdy=%b rc=%0d ll=%b, want st=%0d pr=%b sr=%b rdy=%b rc=%0d ll=%b",
                     e.nm, cyc, state, pll_reset, sys_rst, ready, retry_count, lock_lost,
                     e.st, xpr, xsr, xrdy, e.rc, e.ll);
        end
    endfunction

    // Monitor: compare every snapshot scheduled for the current edge.
    always @(negedge clk) begin
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].c == cyc) begin
                check(sb[i]);
            end else if (sb[i].c < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: snapshot for cyc %0d skipped (now %0d)", sb[i].nm, sb[i].c, cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #50000;
        n_bad++;
        $display("FAIL watchdog: stimulus did not complete, cyc=%0d want <600", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    int b1, b2, b3;

    initial begin
        // ---------------- reset held ----------------
        expect_at(2, "rst_hold", 2'd0, 4'd0, 1'b0);
        wait_cyc(3);
        rst = 1'b0;
        b1 = 4;

        // ---------------- lock, run, loss, relock, flags ----------------
        expect_at(b1+0,   "t1_rstpll_e0", 2'd0, 4'd0, 1'b0);
        expect_at(b1+2,   "t1_rstpll_e2", 2'd0, 4'd0, 1'b0);
        expect_at(b1+3,   "t1_wait_e3",   2'd1, 4'd0, 1'b0);
        expect_at(b1+11,  "t1_wait_e11",  2'd1, 4'd0, 1'b0);
        expect_at(b1+12,  "t1_stable",    2'd2, 4'd0, 1'b0);
        expect_at(b1+19,  "t1_not_yet",   2'd2, 4'd0, 1'b0);
        expect_at(b1+20,  "t1_run",       2'd3, 4'd0, 1'b0);
        expect_at(b1+30,  "t1_run_hold",  2'd3, 4'd0, 1'b0);
        expect_at(b1+42,  "t4_run_late",  2'd3, 4'd0, 1'b0);
        expect_at(b1+43,  "t4_loss",      2'd0, 4'd1, 1'b1);
        expect_at(b1+46,  "t4_rstpll",    2'd0, 4'd1, 1'b1);
        expect_at(b1+47,  "t4_wait",      2'd1, 4'd1, 1'b1);
        expect_at(b1+48,  "t3_stable",    2'd2, 4'd1, 1'b1);
        expect_at(b1+51,  "t3_pre_drop",  2'd2, 4'd1, 1'b1);
        expect_at(b1+52,  "t3_back_wait", 2'd1, 4'd1, 1'b1);
        expect_at(b1+53,  "t3_restable",  2'd2, 4'd1, 1'b1);
        expect_at(b1+56,  "t3_restart",   2'd2, 4'd1, 1'b1);
        expect_at(b1+60,  "t3_not_yet",   2'd2, 4'd1, 1'b1);
        expect_at(b1+61,  "t3_run",       2'd3, 4'd1, 1'b1);
        expect_at(b1+64,  "t5_pre_clr",   2'd3, 4'd1, 1'b1);
        expect_at(b1+65,  "t5_clr_alone", 2'd3, 4'd0, 1'b0);
        expect_at(b1+71,  "t5_run_late",  2'd3, 4'd0, 1'b0);
        expect_at(b1+72,  "t5_clr_vs_ev", 2'd0, 4'd1, 1'b1);
        expect_at(b1+75,  "t5_rstpll",    2'd0, 4'd1, 1'b1);
        expect_at(b1+76,  "t5_wait",      2'd1, 4'd1, 1'b1);
        expect_at(b1+77,  "t5_stable",    2'd2, 4'd1, 1'b1);
        expect_at(b1+84,  "t5_not_yet",   2'd2, 4'd1, 1'b1);
        expect_at(b1+85,  "t5_run",       2'd3, 4'd1, 1'b1);
        expect_at(b1+89,  "t5_pre_clr2",  2'd3, 4'd1, 1'b1);
        expect_at(b1+90,  "t5_clr_later", 2'd3, 4'd0, 1'b0);
        expect_at(b1+101, "t6_run_late",  2'd3, 4'd0, 1'b0);
        expect_at(b1+102, "t6_loss",      2'd0, 4'd1, 1'b1);
        expect_at(b1+106, "t6_wait",      2'd1, 4'd1, 1'b1);
        expect_at(b1+107, "t6_stable",    2'd2, 4'd1, 1'b1);
        expect_at(b1+115, "t6_run",       2'd3, 4'd1, 1'b1);
        expect_at(b1+117, "t6_pre_rst",   2'd3, 4'd1, 1'b1);
        expect_at(b1+118, "t6_rst_run",   2'd0, 4'd0, 1'b0);

        wait_cyc(b1+9);   pll_lock = 1'b1;
        wait_cyc(b1+40);  pll_lock = 1'b0;
        wait_cyc(b1+41);  pll_lock = 1'b1;
        wait_cyc(b1+49);  pll_lock = 1'b0;
        wait_cyc(b1+50);  pll_lock = 1'b1;
        wait_cyc(b1+64);  clear_flags = 1'b1;
        wait_cyc(b1+65);  clear_flags = 1'b0;
        wait_cyc(b1+69);  pll_lock = 1'b0;
        wait_cyc(b1+70);  pll_lock = 1'b1;
        wait_cyc(b1+71);  clear_flags = 1'b1;
        wait_cyc(b1+72);  clear_flags = 1'b0;
        wait_cyc(b1+89);  clear_flags = 1'b1;
        wait_cyc(b1+90);  clear_flags = 1'b0;
        wait_cyc(b1+99);  pll_lock = 1'b0;
        wait_cyc(b1+100); pll_lock = 1'b1;
        wait_cyc(b1+117); rst = 1'b1;
        wait_cyc(b1+118); rst = 1'b0;
        b2 = b1 + 119;

        // ---------------- reset mid-STABLE ----------------
        expect_at(b2+0, "t6b_rstpll", 2'd0, 4'd0, 1'b0);
        expect_at(b2+3, "t6b_wait",   2'd1, 4'd0, 1'b0);
        expect_at(b2+4, "t6b_stable", 2'd2, 4'd0, 1'b0);
        expect_at(b2+6, "t6b_stable2",2'd2, 4'd0, 1'b0);
        expect_at(b2+7, "t6b_rst_stb",2'd0, 4'd0, 1'b0);
        expect_at(b2+8, "t6b_rst_hld",2'd0, 4'd0, 1'b0);
        wait_cyc(b2+6); rst = 1'b1; pll_lock = 1'b0;
        wait_cyc(b2+8); rst = 1'b0;
        b3 = b2 + 9;

        // ---------------- no lock: periodic retries and saturation ----------------
        expect_at(b3+3, "t2_wait", 2'd1, 4'd0, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            int t;
            t = 23 + 24 * (n - 1);
            expect_at(b3+t-1, $sformatf("t2_wait_%0d", n),  2'd1, sat15(n-1), 1'b0);
            expect_at(b3+t,   $sformatf("t2_retry_%0d", n), 2'd0, sat15(n),   1'b0);
        end
        expect_at(b3+410, "t2_clr_sat",   2'd0, 4'd0, 1'b0);
        expect_at(b3+430, "t2_wait_post", 2'd1, 4'd0, 1'b0);
        expect_at(b3+431, "t2_retry_post",2'd0, 4'd1, 1'b0);
        wait_cyc(b3+409); clear_flags = 1'b1;
        wait_cyc(b3+410); clear_flags = 1'b0;
        wait_cyc(b3+432);

        // Drain the scoreboard with a bound.
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        foreach (sb[i]) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: snapshot for cyc %0d never checked", sb[i].nm, sb[i].c);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
